hwpf_nl_issue: RTL

Downstream stage of the next-line prefetch FIFO. It pops one buffered CPU request address at a time and computes the next cache-line address. It drops candidates that cross a page or were recently prefetched, then issues survivors to the hpdcache prefetch request port over a valid/ready handshake. It tracks outstanding prefetches with a transaction-ID bitmap that limits in-flight requests.

---
 rtl/hwpf_nl_issue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hwpf_nl_issue.sv
// Next-line prefetch issue stage: pops one buffered request, derives its next cache line,
// drops page-crossing or recently issued lines, and issues survivors under a TID budget.
module hwpf_nl_issue #(
    parameter int LINE_BYTES      = 64,
    parameter int PAGE_BYTES      = 4096,
    parameter int ADDR_W          = 40,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FILTER_DEPTH    = 4,
    localparam int LOFF  = $clog2(LINE_BYTES),
    localparam int POFF  = $clog2(PAGE_BYTES),
    localparam int TID_W = $clog2(MAX_OUTSTANDING)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              enable_i,
    input  logic              fifo_valid_i,
    input  logic [ADDR_W-1:0] fifo_addr_i,
    output logic              fifo_read_o,
    output logic              dcache_req_valid_o,
    input  logic              dcache_req_ready_i,
    output logic [ADDR_W-1:0] dcache_req_addr_o,
    output logic [TID_W-1:0]  dcache_req_tid_o,
    input  logic              dcache_rsp_valid_i,
    input  logic [TID_W-1:0]  dcache_rsp_tid_i,
    output logic              busy_o,
    output logic [15:0]       issued_cnt_o,
    output logic [15:0]       dropped_cnt_o
);
    localparam int LINE_W = ADDR_W - LOFF;
    localparam int PG_LSB = POFF - LOFF;
    localparam int PTR_W  = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FILTER_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_e;

    state_e                     state_q, state_d;
    logic [LINE_W-1:0]          cand_line_p0;
    logic [LINE_W-1:0]          req_line_p1;
    logic [LINE_W-1:0]          filt_line [FILTER_DEPTH];
    logic [FILTER_DEPTH-1:0]    filt_vld;
    logic [PTR_W-1:0]           filt_ptr;
    logic [MAX_OUTSTANDING-1:0] tid_map, tid_map_d;
    logic [TID_W-1:0]           alloc_tid;
    logic [LINE_W-1:0]          nl_line;
    logic                       free_tid, page_cross, filt_hit, drop, load_req, req_hs;
    logic                       unused_lsb;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Offset bits of the request address never matter: everything works on line numbers.
    assign unused_lsb = ^fifo_addr_i[LOFF-1:0];

    assign free_tid           = ~&tid_map;
    assign fifo_read_o        = ~rst_i & (state_q == IDLE) & enable_i & fifo_valid_i
                                & free_tid & ~flush_i;
    assign dcache_req_valid_o = (state_q == ISSUE) & ~flush_i;
    assign req_hs             = dcache_req_valid_o & dcache_req_ready_i;
    assign dcache_req_addr_o  = {req_line_p1, {LOFF{1'b0}}};
    assign busy_o             = (state_q != IDLE) | (|tid_map);

    assign nl_line    = cand_line_p0 + LINE_W'(1);
    // A wrap to line 0 also changes the page number, so it is dropped here too.
    assign page_cross = nl_line[LINE_W-1:PG_LSB] != cand_line_p0[LINE_W-1:PG_LSB];

    always_comb begin
        alloc_tid = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
            if (!tid_map[i]) alloc_tid = TID_W'(i);
    end

    always_comb begin
        filt_hit = 1'b0;
        for (int i = 0; i < FILTER_DEPTH; i++)
            if (filt_vld[i] && (filt_line[i] == nl_line)) filt_hit = 1'b1;
    end

    // Same-cycle free and allocate: the freed TID can never be the one being issued.
    always_comb begin
        tid_map_d = tid_map;
        if (dcache_rsp_valid_i) tid_map_d[dcache_rsp_tid_i] = 1'b0;
        if (req_hs)             tid_map_d[dcache_req_tid_o] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        drop     = 1'b0;
        load_req = 1'b0;
        unique case (state_q)
            IDLE: if (fifo_read_o) state_d = CHECK;
            CHECK: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (page_cross || filt_hit) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    load_req = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: if (flush_i || req_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: candidate line captured on pop, request line loaded from CHECK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            tid_map          <= '0;
            filt_vld         <= '0;
            filt_ptr         <= '0;
            issued_cnt_o     <= '0;
            dropped_cnt_o    <= '0;
            req_line_p1      <= '0;
            dcache_req_tid_o <= '0;
        end else begin
            state_q <= state_d;
            tid_map <= tid_map_d;
            if (flush_i) begin
                filt_vld <= '0;
                filt_ptr <= '0;
            end else if (req_hs) begin
                filt_vld[filt_ptr] <= 1'b1;
                filt_ptr           <= (filt_ptr == PTR_LAST) ? '0 : filt_ptr + PTR_W'(1);
            end
            if (req_hs) issued_cnt_o  <= sat_inc(issued_cnt_o);
            if (drop)   dropped_cnt_o <= sat_inc(dropped_cnt_o);
            if (load_req) begin
                req_line_p1      <= nl_line;
                dcache_req_tid_o <= alloc_tid;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_read_o) cand_line_p0 <= fifo_addr_i[ADDR_W-1:LOFF];
        if (req_hs)      filt_line[filt_ptr] <= req_line_p1;
    end

endmodule
